ts_pipeline: RTL and testbench

- Parametrised, timestamp-tagging register pipeline carrying a DATA_W payload through STAGES valid/ready register slices.
- A free-running cycle counter stamps each word on ingress acceptance. The stamp travels with the word.
- On egress acceptance the block records the decision timestamp and the word's pipeline latency.
- Sits between the byte/word ingress stage and the decision logic; supersedes the single-slice pass-through register.

---
 rtl/ts_pipeline_pkg.sv | 22 ++
 rtl/ts_pipeline_if.sv | 28 ++
 rtl/ts_pipe_slice.sv | 54 +++++
 rtl/ts_pipeline.sv | 135 +++++++++++++
 tb/tb_ts_pipeline.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_pipeline_pkg.sv
// Shared types and constants for the timestamp-tagging pipeline.
// Default widths match the single-slice register this block replaces.
package ts_pipeline_pkg;

  localparam int DEFAULT_TS_W   = 32;
  localparam int DEFAULT_DATA_W = 8;
  localparam int STAT_W         = 32;

  typedef logic [DEFAULT_TS_W-1:0] ts_t;
  typedef logic [STAT_W-1:0]       stat_t;

  // Payload plus its ingress stamp, as carried by every slice at default widths.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] data;
    ts_t                       ts;
  } stage_t;

  function automatic stat_t sat_inc(input stat_t v);
    return (&v) ? v : v + stat_t'(1);
  endfunction

endpackage

// File: rtl/ts_pipeline_if.sv
// Ingress/egress handshake bundle for ts_pipeline.
// The pipeline takes the slave view; the producer/consumer side takes master.
interface ts_pipeline_if
  import ts_pipeline_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TS_W   = DEFAULT_TS_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ingress_ts;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ingress_ts
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ingress_ts
  );

endinterface

// File: rtl/ts_pipe_slice.sv
// One valid/ready register slice carrying payload plus ingress stamp.
// Loads whenever it is empty or its downstream neighbour is taking its word.
module ts_pipe_slice
  import ts_pipeline_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TS_W   = DEFAULT_TS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TS_W-1:0]   i_ts,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [TS_W-1:0]   o_ts
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } slice_t;

  logic   r_valid;
  slice_t r_stage;
  logic   w_load;

  assign w_load = !r_valid || i_ready;

  // NOTE: state registers use non-blocking assignments so every slice samples
  // its neighbour's pre-edge value; blocking here would shift words through
  // several slices in a single clock depending on evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
    end
  end

  // NOTE: the payload is intentionally left out of reset; r_valid alone decides
  // whether it means anything, so resetting the wide datapath buys nothing.
  always_ff @(posedge clk) begin
    if (w_load && i_valid) begin
      r_stage <= '{data: i_data, ts: i_ts};
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_stage.data;
  assign o_ts    = r_stage.ts;

endmodule

// File: rtl/ts_pipeline.sv
// Timestamp-tagging register pipeline: STAGES slices, free-running stamp counter,
// egress decision stamp and latency. Define TS_PIPELINE_STATS_EN for statistics.
module ts_pipeline
  import ts_pipeline_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int STAGES = 2,
  parameter int TS_W   = DEFAULT_TS_W
) (
  input  logic            clk,
  input  logic            rst_n,
  ts_pipeline_if.slave    bus,
  output logic [TS_W-1:0] decision_ts,
  output logic [TS_W-1:0] latency,
  output logic [TS_W-1:0] cycle_cnt
`ifdef TS_PIPELINE_STATS_EN
  ,
  output logic [TS_W-1:0] max_latency,
  output stat_t           xfer_count,
  output stat_t           stall_count
`endif
);

  logic [TS_W-1:0]   r_cycle_cnt;
  logic [TS_W-1:0]   r_decision_ts;
  logic [TS_W-1:0]   r_latency;

  logic [STAGES-1:0] w_sv;
  logic [STAGES-1:0] w_ready;
  logic [DATA_W-1:0] w_sd [STAGES];
  logic [TS_W-1:0]   w_st [STAGES];
  logic              w_out_xfer;
  logic [TS_W-1:0]   w_lat_now;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    logic              w_up_valid;
    logic [DATA_W-1:0] w_up_data;
    logic [TS_W-1:0]   w_up_ts;
    logic              w_dn_ready;

    // ready_g = !valid_g || ready_{g+1}, unrolled so it depends only on
    // registered valids and out_ready rather than on its own neighbours.
    assign w_ready[g] = bus.out_ready || !(&w_sv[STAGES-1:g]);

    if (g == 0) begin : g_head
      assign w_up_valid = bus.in_valid;
      assign w_up_data  = bus.in_data;
      assign w_up_ts    = r_cycle_cnt;
    end else begin : g_body
      assign w_up_valid = w_sv[g-1];
      assign w_up_data  = w_sd[g-1];
      assign w_up_ts    = w_st[g-1];
    end

    if (g == STAGES-1) begin : g_tail
      assign w_dn_ready = bus.out_ready;
    end else begin : g_inner
      assign w_dn_ready = w_ready[g+1];
    end

    ts_pipe_slice #(
      .DATA_W (DATA_W),
      .TS_W   (TS_W)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_up_valid),
      .i_data  (w_up_data),
      .i_ts    (w_up_ts),
      .i_ready (w_dn_ready),
      .o_valid (w_sv[g]),
      .o_data  (w_sd[g]),
      .o_ts    (w_st[g])
    );
  end

  assign bus.in_ready       = w_ready[0];
  assign bus.out_valid      = w_sv[STAGES-1];
  assign bus.out_data       = w_sd[STAGES-1];
  assign bus.out_ingress_ts = w_sv[STAGES-1] ? w_st[STAGES-1] : '0;

  assign w_out_xfer = w_sv[STAGES-1] && bus.out_ready;
  // Modular subtraction keeps the latency correct across counter wrap.
  assign w_lat_now  = r_cycle_cnt - w_st[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_decision_ts <= '0;
      r_latency     <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + TS_W'(1);
      if (w_out_xfer) begin
        r_decision_ts <= r_cycle_cnt;
        r_latency     <= w_lat_now;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign decision_ts = r_decision_ts;
  assign latency     = r_latency;

`ifdef TS_PIPELINE_STATS_EN
  logic [TS_W-1:0] r_max_latency;
  stat_t           r_xfer_count;
  stat_t           r_stall_count;
  logic            w_in_stall;

  assign w_in_stall = bus.in_valid && !w_ready[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_latency <= '0;
      r_xfer_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_out_xfer) begin
        r_xfer_count <= sat_inc(r_xfer_count);
        if (w_lat_now > r_max_latency) begin
          r_max_latency <= w_lat_now;
        end
      end
      if (w_in_stall) begin
        r_stall_count <= sat_inc(r_stall_count);
      end
    end
  end

  assign max_latency = r_max_latency;
  assign xfer_count  = r_xfer_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_ts_pipeline.sv
// Self-checking bench for ts_pipeline (TS_W=8 so counter wrap is reachable).
// Occupancy/arrival-time queue model plus directed tables and sequences.
module tb_ts_pipeline;

  localparam int DATA_W = 8;
  localparam int STAGES = 2;
  localparam int TS_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ts_pipeline_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  logic [TS_W-1:0] decision_ts;
  logic [TS_W-1:0] latency;
  logic [TS_W-1:0] cycle_cnt;
`ifdef TS_PIPELINE_STATS_EN
  logic [TS_W-1:0] max_latency;
  logic [31:0]     xfer_count;
  logic [31:0]     stall_count;
`endif

  ts_pipeline #(
    .DATA_W (DATA_W),
    .STAGES (STAGES),
    .TS_W   (TS_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .decision_ts (decision_ts),
    .latency     (latency),
    .cycle_cnt   (cycle_cnt)
`ifdef TS_PIPELINE_STATS_EN
    ,
    .max_latency (max_latency),
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words in flight with their stamp and acceptance cycle.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
    int                a;
  } mword_t;

  mword_t          q[$];
  logic [TS_W-1:0] m_cnt, m_dec, m_lat, m_max;
  logic [31:0]     m_xfer, m_stall;
  int              t, last_e;
  bit              m_acc;

  logic              s_in_ready, s_out_valid;
  logic [DATA_W-1:0] s_out_data;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              v;
    logic              r;
    logic              ir;
    logic              ov;
    logic [DATA_W-1:0] od;
    int                lat;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt   = '0;
    m_dec   = '0;
    m_lat   = '0;
    m_max   = '0;
    m_xfer  = '0;
    m_stall = '0;
    t       = 0;
    last_e  = -1000;
    m_acc   = 1'b0;
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks its effect at once.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("rst_decision_ts", 64'(decision_ts), 64'd0);
    check("rst_latency", 64'(latency), 64'd0);
    check("rst_ingress_ts", 64'(bus.out_ingress_ts), 64'd0);
`ifdef TS_PIPELINE_STATS_EN
    check("rst_max_latency", 64'(max_latency), 64'd0);
    check("rst_xfer_count", 64'(xfer_count), 64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance the model.
  task automatic cycle_step(input logic [DATA_W-1:0] d, input logic v, input logic r);
    bit     exp_ir, exp_ov;
    int     ready_at;
    mword_t w;
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = r;
    @(negedge clk);
    exp_ir = (q.size() < STAGES) || r;
    exp_ov = 1'b0;
    if (q.size() > 0) begin
      ready_at = q[0].a + STAGES;
      if (last_e + 1 > ready_at) ready_at = last_e + 1;
      exp_ov = (t >= ready_at);
    end
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    check($sformatf("in_ready@%0d", t), 64'(bus.in_ready), 64'(exp_ir));
    check($sformatf("out_valid@%0d", t), 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check($sformatf("out_data@%0d", t), 64'(bus.out_data), 64'(q[0].data));
      check($sformatf("out_ingress_ts@%0d", t), 64'(bus.out_ingress_ts), 64'(q[0].ts));
    end
    check($sformatf("cycle_cnt@%0d", t), 64'(cycle_cnt), 64'(m_cnt));
    check($sformatf("decision_ts@%0d", t), 64'(decision_ts), 64'(m_dec));
    check($sformatf("latency@%0d", t), 64'(latency), 64'(m_lat));
`ifdef TS_PIPELINE_STATS_EN
    check($sformatf("max_latency@%0d", t), 64'(max_latency), 64'(m_max));
    check($sformatf("xfer_count@%0d", t), 64'(xfer_count), 64'(m_xfer));
    check($sformatf("stall_count@%0d", t), 64'(stall_count), 64'(m_stall));
`endif
    if (exp_ov && r) begin
      w      = q.pop_front();
      m_dec  = m_cnt;
      m_lat  = m_cnt - w.ts;
      last_e = t;
      if (m_lat > m_max) m_max = m_lat;
      m_xfer = m_xfer + 32'd1;
    end
    if (v && !exp_ir) m_stall = m_stall + 32'd1;
    m_acc = v && exp_ir;
    if (m_acc) q.push_back('{d, m_cnt, t});
    m_cnt = m_cnt + TS_W'(1);
    t++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int             n_xfer, n_low;
    logic [DATA_W-1:0] rd;
    logic           rv;

    // Backpressure scenario, STAGES=2, starting from an empty pipe.
    tbl[0] = '{8'h30, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, -1};
    tbl[1] = '{8'h31, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, -1};
    tbl[2] = '{8'h32, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30, -1};
    tbl[3] = '{8'h32, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30, -1};
    tbl[4] = '{8'h32, 1'b1, 1'b1, 1'b1, 1'b1, 8'h30,  4};
    tbl[5] = '{8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31,  4};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h32,  2};
    tbl[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33,  2};
    tbl[8] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, -1};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Single word accepted at cycle_cnt=10.
    repeat (10) cycle_step(8'h00, 1'b0, 1'b1);
    check("t1_cnt_at_accept", 64'(cycle_cnt), 64'd10);
    cycle_step(8'hA5, 1'b1, 1'b1);
    check("t1_not_yet_valid", 64'(bus.out_valid), 64'd0);
    cycle_step(8'h00, 1'b0, 1'b1);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_data", 64'(bus.out_data), 64'hA5);
    check("t1_ingress_ts", 64'(bus.out_ingress_ts), 64'd10);
    cycle_step(8'h00, 1'b0, 1'b1);
    check("t1_latency", 64'(latency), 64'd2);
    check("t1_decision_ts", 64'(decision_ts), 64'd12);

    // Back-to-back stream of 16 words.
    n_xfer = 0;
    n_low  = 0;
    for (int i = 0; i < 18; i++) begin
      cycle_step(DATA_W'(i), (i < 16), 1'b1);
      if (!s_in_ready) n_low++;
      if (s_out_valid) n_xfer++;
    end
    check("t2_xfers", 64'(n_xfer), 64'd16);
    check("t2_in_ready_low", 64'(n_low), 64'd0);
    check("t2_latency", 64'(latency), 64'd2);

    // Backpressure table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle_step(tbl[i].d, tbl[i].v, tbl[i].r);
      check($sformatf("t3_in_ready_%0d", i), 64'(s_in_ready), 64'(tbl[i].ir));
      check($sformatf("t3_out_valid_%0d", i), 64'(s_out_valid), 64'(tbl[i].ov));
      if (tbl[i].ov) check($sformatf("t3_out_data_%0d", i), 64'(s_out_data), 64'(tbl[i].od));
      if (tbl[i].lat >= 0) check($sformatf("t3_latency_%0d", i), 64'(latency), 64'(tbl[i].lat));
    end
`ifdef TS_PIPELINE_STATS_EN
    check("t6_xfer_count", 64'(xfer_count), 64'd4);
    check("t6_stall_count", 64'(stall_count), 64'd2);
    check("t6_max_latency", 64'(max_latency), 64'd4);
`endif

    // Counter wrap: accept at 0xFE, egress at 0x00.
    for (int k = 0; k < 300 && m_cnt != 8'hFE; k++) cycle_step(8'h00, 1'b0, 1'b1);
    check("t4_cnt_fe", 64'(cycle_cnt), 64'hFE);
    cycle_step(8'hC3, 1'b1, 1'b1);
    cycle_step(8'h00, 1'b0, 1'b1);
    check("t4_out_valid", 64'(bus.out_valid), 64'd1);
    check("t4_ingress_ts", 64'(bus.out_ingress_ts), 64'hFE);
    cycle_step(8'h00, 1'b0, 1'b1);
    check("t4_latency", 64'(latency), 64'd2);
    check("t4_decision_ts", 64'(decision_ts), 64'd0);

    // Reset with two words in flight.
    cycle_step(8'h55, 1'b1, 1'b0);
    cycle_step(8'h66, 1'b1, 1'b0);
    check("t5_full_before_reset", 64'(bus.out_valid), 64'd1);
    do_reset();
    n_xfer = 0;
    for (int i = 0; i < 6; i++) begin
      cycle_step(8'h00, 1'b0, 1'b1);
      if (s_out_valid) n_xfer++;
    end
    check("t5_no_stale_word", 64'(n_xfer), 64'd0);

    // Randomised traffic against the model; a refused word is held until taken.
    do_reset();
    rv = 1'b0;
    rd = '0;
    for (int k = 0; k < 2000; k++) begin
      if (!(rv && !m_acc)) begin
        rv = ($urandom_range(0, 99) < 60);
        rd = DATA_W'($urandom);
      end
      cycle_step(rd, rv, ($urandom_range(0, 99) < 70));
    end
    repeat (4) cycle_step(8'h00, 1'b0, 1'b1);
    check("rand_drained", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
